// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer: FSM encodings, default widths,
// register-file index constants and the writeback-eligibility helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_REQ  = 2'd1,
    MAU_WB   = 2'd2
  } mau_state_e;

  localparam int MAU_ADDR_W   = 12;
  localparam int MAU_DATA_W   = 8;
  localparam int MAU_NUM_REGS = 11;
  localparam int MAU_TIMEOUT  = 255;

  // RM0/RM1 sit just above the writable GPRs, so loads aimed at them never write back.
  localparam logic [3:0] RM0 = 4'd11;
  localparam logic [3:0] RM1 = 4'd12;

  function automatic logic reg_writable(input logic [3:0] idx, input int num_regs);
    return int'(idx) < num_regs;
  endfunction

endpackage

// File: rtl/mem_access_unit_watchdog.sv
// Bus watchdog for mem_access_unit: counts REQ cycles without an ack and flags
// expiry on the cycle that would reach TIMEOUT.
module mau_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry fires on the TIMEOUT-th ack-less REQ cycle, so ram_req is high exactly TIMEOUT cycles.
  assign expire_o = tick_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the register file and the data-RAM req/ack bus.
// Optional bus timeout with abort is built when MAU_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W   = MAU_ADDR_W,
  parameter int DATA_W   = MAU_DATA_W,
  parameter int NUM_REGS = MAU_NUM_REGS,
  parameter int TIMEOUT  = MAU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [3:0]        rd,
  input  logic [DATA_W-1:0] st_data,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              gpr_we,
  output logic [3:0]        gpr_waddr,
  output logic [DATA_W-1:0] gpr_wdata
);

  mau_state_e        state_q;
  logic              busy_q;
  logic              done_q;
  logic              req_q;
  logic              is_store_q;
  logic [3:0]        rd_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              gpr_we_q;
  logic [3:0]        gpr_waddr_q;
  logic [DATA_W-1:0] gpr_wdata_q;
  logic              accept;
  logic              expire;

  assign accept = (state_q == MAU_IDLE) && !busy_q && start;

`ifdef MAU_TIMEOUT_EN
  logic err_q;

  mau_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .tick_i   ((state_q == MAU_REQ) && !ram_ack),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= expire;
    end
  end

  assign err = err_q;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // busy stays up through the done cycle; IDLE spends one cycle clearing it before accepting again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MAU_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
      is_store_q  <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      gpr_we_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
    end else begin
      done_q   <= 1'b0;
      gpr_we_q <= 1'b0;
      case (state_q)
        MAU_IDLE: begin
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            busy_q     <= 1'b1;
            req_q      <= 1'b1;
            is_store_q <= is_store;
            rd_q       <= rd;
            data_q     <= st_data;
            addr_q     <= addr_in;
            state_q    <= MAU_REQ;
          end
        end
        MAU_REQ: begin
          if (ram_ack) begin
            req_q <= 1'b0;
            if (is_store_q) begin
              done_q  <= 1'b1;
              state_q <= MAU_IDLE;
            end else begin
              data_q  <= ram_rdata;
              state_q <= MAU_WB;
            end
          end else if (expire) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MAU_IDLE;
          end
        end
        MAU_WB: begin
          gpr_we_q    <= reg_writable(rd_q, NUM_REGS);
          gpr_waddr_q <= rd_q;
          gpr_wdata_q <= data_q;
          done_q      <= 1'b1;
          state_q     <= MAU_IDLE;
        end
        default: begin
          state_q <= MAU_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_req   = req_q;
  assign ram_we    = is_store_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = data_q;
  assign gpr_we    = gpr_we_q;
  assign gpr_waddr = gpr_waddr_q;
  assign gpr_wdata = gpr_wdata_q;

endmodule
